// File: rtl/adder_pkg.sv
// Shared types and constants for the digit-serial arithmetic blocks.
package adder_pkg;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   localparam int unsigned DefaultWidth = 16;
   localparam int unsigned DefaultDigit = 4;

   // Number of digit cycles needed to cover a full operand.
   function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
      return width / digit;
   endfunction

endpackage

// File: rtl/serial_adder_n_if.sv
// Operand/result bundle for serial_adder_n; master drives operands, slave returns results.
interface serial_adder_n_if
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             carry_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;

   modport master (
      output start, sub, a, b, carry_in,
      input  busy, done, sum, carry_out, overflow
   );

   modport slave (
      input  start, sub, a, b, carry_in,
      output busy, done, sum, carry_out, overflow
   );
endinterface

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry slice built from fulladder cells.
module digit_adder
   import adder_pkg::*;
#(
   parameter int unsigned DIGIT = DefaultDigit
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             carry_in,
   output logic [DIGIT-1:0] sum,
   output logic             carry_out
);
   logic [DIGIT:0] c;

   assign c[0] = carry_in;

   for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      fulladder u_fa (
         .a_i (a[i]),
         .b_i (b[i]),
         .c_i (c[i]),
         .s_o (sum[i]),
         .c_o (c[i+1])
      );
   end

   assign carry_out = c[DIGIT];
endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell.
module fulladder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder_n.sv
// Digit-serial add/subtract unit: WIDTH bits in WIDTH/DIGIT cycles, LS digit first,
// with start/busy/done handshake, raw carry out and two's-complement overflow.
module serial_adder_n
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned DIGIT = DefaultDigit
) (
   input logic             clk,
   input logic             rst,
   serial_adder_n_if.slave io
);
   localparam int unsigned N       = num_digits(WIDTH, DIGIT);
   localparam int unsigned CntW    = (N > 1) ? $clog2(N) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

   if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
      $error("serial_adder_n: WIDTH must be a positive multiple of DIGIT");
   end

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] beff_q, beff_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_out_q, carry_out_d;
   logic             overflow_q, overflow_d;
   logic             done_q, done_d;

   logic [DIGIT-1:0] dig_a, dig_b, dig_s;
   logic             dig_co;
   logic [WIDTH-1:0] shifted;

   assign dig_a = a_q[DIGIT*int'(cnt_q) +: DIGIT];
   assign dig_b = beff_q[DIGIT*int'(cnt_q) +: DIGIT];

   digit_adder #(
      .DIGIT (DIGIT)
   ) u_digit (
      .a         (dig_a),
      .b         (dig_b),
      .carry_in  (carry_q),
      .sum       (dig_s),
      .carry_out (dig_co)
   );

   // New digit enters at the MSB end so the last digit lands in place.
   if (DIGIT == WIDTH) begin : g_single
      assign shifted = dig_s;
   end else begin : g_multi
      assign shifted = {dig_s, shift_q[WIDTH-1:DIGIT]};
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      beff_d      = beff_q;
      carry_d     = carry_q;
      shift_d     = shift_q;
      sum_d       = sum_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      done_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (io.start) begin
               state_d = S_RUN;
               cnt_d   = '0;
               a_d     = io.a;
               beff_d  = io.sub ? ~io.b : io.b;
               carry_d = io.sub ^ io.carry_in;
            end
         end
         S_RUN: begin
            shift_d = shifted;
            carry_d = dig_co;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               state_d     = S_IDLE;
               sum_d       = shifted;
               carry_out_d = dig_co;
               overflow_d  = (a_q[WIDTH-1] == beff_q[WIDTH-1]) &&
                             (shifted[WIDTH-1] != a_q[WIDTH-1]);
               done_d      = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         beff_q      <= '0;
         carry_q     <= 1'b0;
         shift_q     <= '0;
         sum_q       <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         beff_q      <= beff_d;
         carry_q     <= carry_d;
         shift_q     <= shift_d;
         sum_q       <= sum_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         done_q      <= done_d;
      end
   end

   assign io.busy      = (state_q == S_RUN);
   assign io.done      = done_q;
   assign io.sum       = sum_q;
   assign io.carry_out = carry_out_q;
   assign io.overflow  = overflow_q;
endmodule
